// File: rtl/imem_loader_if.sv
// Bundle of load-control, byte-stream, fetch and memory signals for imem_loader.
// slave = the loader itself, master = the driving environment.
interface imem_loader_if;
    logic        ld_start;
    logic [14:0] ld_len;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        ld_busy;
    logic        ld_done;
    logic        ld_err;
    logic        fetch_req;
    logic [13:0] fetch_addr;
    logic [31:0] fetch_data;
    logic        fetch_valid;
    logic        core_stall;
    logic        mem_ren;
    logic        mem_wen;
    logic [13:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  ld_start, ld_len, byte_valid, byte_data, fetch_req, fetch_addr, mem_rdata,
        output byte_ready, ld_busy, ld_done, ld_err, fetch_data, fetch_valid, core_stall,
               mem_ren, mem_wen, mem_addr, mem_wdata
    );

    modport master (
        output ld_start, ld_len, byte_valid, byte_data, fetch_req, fetch_addr, mem_rdata,
        input  byte_ready, ld_busy, ld_done, ld_err, fetch_data, fetch_valid, core_stall,
               mem_ren, mem_wen, mem_addr, mem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory loader: assembles a little-endian byte stream into 32-bit words
// and writes them to memory, stalling the core; passes core fetches through when idle.
module imem_loader #(
    parameter logic [13:0] START_ADDR = 14'h0000,
    parameter int unsigned TIMEOUT    = 1024
) (
    input logic          clk,
    input logic          rst,
    imem_loader_if.slave bus
);

    typedef enum logic [2:0] {IDLE, LOAD, WRITE, DONE, ERR} state_t;

    localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);

    state_t      state_q, state_d;
    logic [14:0] len_q, len_d;
    logic [14:0] word_cnt_q, word_cnt_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [15:0] idle_cnt_q, idle_cnt_d;
    logic [31:0] asm_q, asm_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            len_q      <= '0;
            word_cnt_q <= '0;
            byte_cnt_q <= '0;
            idle_cnt_q <= '0;
            asm_q      <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            word_cnt_q <= word_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            idle_cnt_q <= idle_cnt_d;
            asm_q      <= asm_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        word_cnt_d = word_cnt_q;
        byte_cnt_d = byte_cnt_q;
        idle_cnt_d = idle_cnt_q;
        asm_d      = asm_q;

        bus.byte_ready  = 1'b0;
        bus.ld_busy     = 1'b1;
        bus.core_stall  = 1'b1;
        bus.ld_done     = 1'b0;
        bus.ld_err      = 1'b0;
        bus.fetch_valid = 1'b0;
        bus.fetch_data  = '0;
        bus.mem_ren     = 1'b0;
        bus.mem_wen     = 1'b0;
        bus.mem_addr    = START_ADDR + word_cnt_q[13:0];
        bus.mem_wdata   = asm_q;

        unique case (state_q)
            IDLE: begin
                bus.ld_busy     = 1'b0;
                bus.core_stall  = 1'b0;
                bus.mem_ren     = bus.fetch_req;
                bus.mem_addr    = bus.fetch_addr;
                bus.fetch_valid = bus.fetch_req;
                bus.fetch_data  = bus.mem_rdata;
                if (bus.ld_start) begin
                    len_d      = bus.ld_len;
                    word_cnt_d = '0;
                    byte_cnt_d = '0;
                    idle_cnt_d = '0;
                    state_d    = (bus.ld_len != '0) ? LOAD : DONE;
                end
            end
            LOAD: begin
                bus.byte_ready = 1'b1;
                if (bus.byte_valid) begin
                    asm_d[{byte_cnt_q, 3'b000} +: 8] = bus.byte_data;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    idle_cnt_d = '0;
                    if (byte_cnt_q == 2'd3) state_d = WRITE;
                end else begin
                    idle_cnt_d = idle_cnt_q + 16'd1;
                    if (idle_cnt_d == TIMEOUT_W) state_d = ERR;
                end
            end
            WRITE: begin
                bus.mem_wen = 1'b1;
                word_cnt_d  = word_cnt_q + 15'd1;
                state_d     = (word_cnt_d == len_q) ? DONE : LOAD;
            end
            DONE: begin
                bus.ld_done = 1'b1;
                state_d     = IDLE;
            end
            ERR: begin
                bus.ld_err = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
